// File: rtl/fc_accumulator.sv
// Per-neuron partial-sum accumulator for the FC column. It accumulates a configured number
// of chunks per neuron, then requantizes (round-half-up shift) and saturates each finished sum.
module fc_accumulator #(
    parameter int DATA_WIDTH      = 8,
    parameter int PSUM_WIDTH      = 20,
    parameter int ACC_WIDTH       = 24,
    parameter int CHUNK_CNT_WIDTH = 8,
    parameter int OUT_CNT_WIDTH   = 10,
    parameter int SHIFT_WIDTH     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [CHUNK_CNT_WIDTH-1:0] cfg_num_chunks_i,
    input  logic [OUT_CNT_WIDTH-1:0]   cfg_num_out_i,
    input  logic [SHIFT_WIDTH-1:0]     cfg_shift_i,
    input  logic                       psum_valid_i,
    input  logic [PSUM_WIDTH-1:0]      psum_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       acc_valid_o,
    output logic                       acc_last_o,
    output logic [DATA_WIDTH-1:0]      acc_result_o
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic signed [ACC_WIDTH:0] QMAX = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] QMIN = ~QMAX;

    state_t                       state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic [CHUNK_CNT_WIDTH-1:0]   chunk_cnt;
    logic [OUT_CNT_WIDTH-1:0]     out_cnt;
    logic [CHUNK_CNT_WIDTH-1:0]   num_chunks;
    logic [OUT_CNT_WIDTH-1:0]     num_out;
    logic [SHIFT_WIDTH-1:0]       shift;

    logic signed [ACC_WIDTH-1:0]  sum_next;
    logic signed [ACC_WIDTH:0]    ext;
    logic signed [ACC_WIDTH:0]    rnd;
    logic signed [ACC_WIDTH:0]    y;
    logic [DATA_WIDTH-1:0]        sat;
    logic                         last_chunk;
    logic                         last_out;

    // Rounding is done one bit wider so that adding the half-LSB cannot overflow.
    always_comb begin
        sum_next = acc + ACC_WIDTH'(signed'(psum_i));
        ext      = (ACC_WIDTH+1)'(sum_next);
        rnd      = (ACC_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
        y        = (shift == '0) ? ext : ((ext + rnd) >>> shift);
        if (y > QMAX)
            sat = QMAX[DATA_WIDTH-1:0];
        else if (y < QMIN)
            sat = QMIN[DATA_WIDTH-1:0];
        else
            sat = y[DATA_WIDTH-1:0];
    end

    assign last_chunk = (chunk_cnt == num_chunks - CHUNK_CNT_WIDTH'(1));
    assign last_out   = (out_cnt == num_out - OUT_CNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            chunk_cnt    <= '0;
            out_cnt      <= '0;
            num_chunks   <= '0;
            num_out      <= '0;
            shift        <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            acc_valid_o  <= 1'b0;
            acc_last_o   <= 1'b0;
            acc_result_o <= '0;
        end else begin
            done_o       <= 1'b0;
            acc_valid_o  <= 1'b0;
            acc_last_o   <= 1'b0;
            acc_result_o <= '0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        num_chunks <= (cfg_num_chunks_i == '0) ? CHUNK_CNT_WIDTH'(1) : cfg_num_chunks_i;
                        num_out    <= (cfg_num_out_i == '0) ? OUT_CNT_WIDTH'(1) : cfg_num_out_i;
                        shift      <= cfg_shift_i;
                        acc        <= '0;
                        chunk_cnt  <= '0;
                        out_cnt    <= '0;
                        busy_o     <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (psum_valid_i) begin
                        if (last_chunk) begin
                            // Clearing acc here lets the next neuron start on the following cycle.
                            acc          <= '0;
                            chunk_cnt    <= '0;
                            acc_valid_o  <= 1'b1;
                            acc_result_o <= sat;
                            if (last_out) begin
                                acc_last_o <= 1'b1;
                                done_o     <= 1'b1;
                                busy_o     <= 1'b0;
                                out_cnt    <= '0;
                                state      <= IDLE;
                            end else begin
                                out_cnt <= out_cnt + OUT_CNT_WIDTH'(1);
                            end
                        end else begin
                            acc       <= sum_next;
                            chunk_cnt <= chunk_cnt + CHUNK_CNT_WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
